vc_test_rand_delay_src_lfsr: RTL
================================

// Module: vc_test_rand_delay_src_lfsr
// PURPOSE
//  Test-only val/rdy message source. It is the transmit end of the handshake that test sinks consume.
//  - Streams num_msgs entries from an internal memory m[] in index order.
//  - Inserts a pseudo-random number of idle cycles before each message, bounded by max_delay.
//  - Raises done after the last message is accepted.
//  - Used in unit-test harnesses to stress the rdy-side behaviour of the design under test.
// PARAMETERS
//  p_msg_nbits  8      message width in bits
//  p_num_msgs   1024   depth of message memory m[]
//  p_seed       16'hACE1  LFSR reset value; must be nonzero
// PORTS
//  clk        in   1            clock; all state updates on posedge
//  reset      in   1            synchronous, active-low: sampled at posedge, state cleared when 0
//  max_delay  in   32           maximum idle cycles inserted per message
//  num_msgs   in   32           number of valid entries in m[]; 0..p_num_msgs
//  val        out  1            message valid
//  rdy        in   1            downstream ready
//  msg        out  p_msg_nbits  current message, m[idx]
//  done       out  1            all num_msgs messages accepted
// BEHAVIOUR
//  Memory
//   - m[0:p_num_msgs-1] is written only by the testbench, via hierarchical reference.
//   - The block never writes m[].
//  Index
//   - idx is 32-bit and resets to 0.
//   - idx increments by 1 on each handshake (val && rdy at posedge).
//  LFSR
//   - 16-bit Galois LFSR, taps 16'hB400, resets to p_seed.
//   - Steps once per handshake only.
//  Delay draw
//   - d = lfsr % ({1'b0,max_delay} + 1), computed in 33 bits so max_delay = 32'hFFFFFFFF does not overflow.
//   - max_delay = 0 forces d = 0.
//  FSM: DELAY, SEND, DONE
//   - Load rule: if d == 0, next state is SEND; otherwise next state is DELAY with count = d.
//   - Reset:
//     - idx = 0, lfsr = p_seed.
//     - If num_msgs == 0, state = DONE.
//     - Otherwise apply the load rule using d drawn from p_seed.
//   - DELAY: val = 0; count decrements each cycle; when count == 1, next state is SEND.
//     - Result: exactly d idle cycles per message.
//   - SEND: val = 1 and msg = m[idx].
//     - msg holds stable while val && !rdy.
//     - On handshake: idx++ and the LFSR steps.
//     - If idx+1 == num_msgs, next state is DONE.
//     - Otherwise apply the load rule with d drawn from the stepped LFSR value.
//   - DONE: val = 0, done = 1; stays here until reset.
//  Outputs
//   - val and done are decoded from state (Moore); no combinational path from rdy.
//   - Reset values: val = 0 (1 when the reset draw gives d = 0 and num_msgs > 0), done = (num_msgs == 0).
//   - msg is 0 whenever val = 0.
//  Boundary conditions
//   - rdy held low: stays in SEND indefinitely; idx, lfsr and msg frozen.
//   - Reset asserted mid-message: idx and lfsr restart, stream replays from m[0] with the same delay sequence.
//   - num_msgs > p_num_msgs: clamp the stream length to p_num_msgs.
//   - Changing max_delay: affects only subsequent draws; a count in progress is not altered.
// STRUCTURE
//  - Shared header vc-test-rand.v:
//    - LFSR tap constant VC_LFSR16_TAPS = 16'hB400.
//    - State encodings DELAY = 2'd0, SEND = 2'd1, DONE = 2'd2.
//  - Sub-module vc_lfsr16: ports clk, reset, en, seed, out.
//  - Top level holds the FSM, delay counter, idx register, m[] array and trace task.
//    - Trace prints msg in hex when val && rdy, "#" when val && !rdy, blank otherwise.
// TESTING (harness: this source feeding the existing random-delay sink, which has its own max_delay; done = src.done && sink.done)
//  - Zero delays: num_msgs = 8, m[i] = i, both max_delays = 0.
//    -> val is 1 from the first cycle after reset; 8 consecutive handshakes; done at cycle 8.
//  - Source delay 3, sink delay 0: delay draws match a reference LFSR model stepped per handshake.
//    -> exactly d idle cycles before each message; in-order 00..07 received.
//  - Sink backpressure (sink max_delay 10):
//    -> msg stable whenever val && !rdy; no message dropped or duplicated; done within 5000 cycles.
//  - Edge counts: num_msgs = 0 -> done = 1 and val = 0 immediately after reset.
//    num_msgs = 1 -> exactly one handshake, then DONE.
//  - Mid-stream reset: drive reset = 0 after 3 handshakes, release.
//    -> stream restarts at m[0]; same idle-gap sequence as the first run.
//  - max_delay = 32'hFFFFFFFF: no arithmetic overflow; every gap satisfies d <= 16'hFFFF.
//    Reduce num_msgs to 2 and raise the cycle limit for this run.

Source files
------------

// File: rtl/vc_test_rand_delay_src_lfsr_pkg.sv
// =============================================================================
// Module : vc_test_rand_delay_src_lfsr_pkg
// Brief  : Shared LFSR taps, source FSM states and delay-draw helpers.
// Rev    : 1.0
// =============================================================================
`default_nettype none

package vc_test_rand_delay_src_lfsr_pkg;

    localparam logic [15:0] VC_LFSR16_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        DELAY = 2'd0,
        SEND  = 2'd1,
        DONE  = 2'd2
    } src_state_t;

    function automatic logic [15:0] lfsr16_step(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ VC_LFSR16_TAPS) : (cur >> 1);
    endfunction

    // 33-bit divisor so max_delay = 32'hFFFFFFFF still yields a nonzero span.
    function automatic logic [15:0] delay_draw(input logic [15:0] lfsr,
                                               input logic [31:0] max_delay);
        logic [32:0] span;
        span = {1'b0, max_delay} + 33'd1;
        return 16'({17'd0, lfsr} % span);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vc_test_rand_delay_src_lfsr_if.sv
// =============================================================================
// Module : vc_test_rand_delay_src_lfsr_if
// Brief  : val/rdy message handshake between the test source and its sink.
// Rev    : 1.0
// =============================================================================
`default_nettype none

interface vc_test_rand_delay_src_lfsr_if #(
    parameter int p_msg_nbits = 8
);
    logic                   val;
    logic                   rdy;
    logic [p_msg_nbits-1:0] msg;

    modport master (output val, output msg, input rdy);
    modport slave  (input val, input msg, output rdy);
endinterface

`default_nettype wire

// File: rtl/vc_test_rand_delay_src_lfsr_lfsr16.sv
// =============================================================================
// Module : vc_lfsr16
// Brief  : 16-bit Galois LFSR, loads seed in reset and steps when en is high.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module vc_lfsr16
    import vc_test_rand_delay_src_lfsr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            out <= seed;
        end else if (en) begin
            out <= lfsr16_step(out);
        end
    end

endmodule

`default_nettype wire

// File: rtl/vc_test_rand_delay_src_lfsr.sv
// =============================================================================
// Module : vc_test_rand_delay_src_lfsr
// Brief  : Test message source streaming m[] with random idle gaps per message.
// Rev    : 1.0
// =============================================================================
`default_nettype none

module vc_test_rand_delay_src_lfsr
    import vc_test_rand_delay_src_lfsr_pkg::*;
#(
    parameter int          p_msg_nbits = 8,
    parameter int          p_num_msgs  = 1024,
    parameter logic [15:0] p_seed      = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   max_delay,
    input  logic [31:0]                   num_msgs,
    vc_test_rand_delay_src_lfsr_if.master src,
    output logic                          done
);

    localparam int c_aw = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;

    // Loaded by the test harness through hierarchical reference only.
    logic [p_msg_nbits-1:0] m [0:p_num_msgs-1];

    src_state_t  r_state;
    src_state_t  w_state_next;
    logic [15:0] r_count;
    logic [15:0] w_count_next;
    logic [31:0] r_idx;
    logic [31:0] w_idx_next;
    logic        w_lfsr_en;
    logic [15:0] w_lfsr;
    logic [15:0] w_draw;
    logic [15:0] w_draw_reset;
    logic [31:0] w_len;

    assign w_len        = (num_msgs > 32'(p_num_msgs)) ? 32'(p_num_msgs) : num_msgs;
    assign w_draw_reset = delay_draw(p_seed, max_delay);
    assign w_draw       = delay_draw(lfsr16_step(w_lfsr), max_delay);

    vc_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (w_lfsr_en),
        .seed  (p_seed),
        .out   (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx <= '0;
            if (w_len == 32'd0) begin
                r_state <= DONE;
                r_count <= '0;
            end else if (w_draw_reset == 16'd0) begin
                r_state <= SEND;
                r_count <= '0;
            end else begin
                r_state <= DELAY;
                r_count <= w_draw_reset;
            end
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_idx_next   = r_idx;
        w_lfsr_en    = 1'b0;
        case (r_state)
            DELAY: begin
                w_count_next = r_count - 16'd1;
                if (r_count == 16'd1) begin
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (src.rdy) begin
                    w_idx_next = r_idx + 32'd1;
                    w_lfsr_en  = 1'b1;
                    if (r_idx + 32'd1 == w_len) begin
                        w_state_next = DONE;
                    end else if (w_draw == 16'd0) begin
                        w_state_next = SEND;
                    end else begin
                        w_state_next = DELAY;
                        w_count_next = w_draw;
                    end
                end
            end
            DONE:    w_state_next = DONE;
            default: w_state_next = DONE;
        endcase
    end

    assign src.val = (r_state == SEND);
    assign done    = (r_state == DONE);
    assign src.msg = src.val ? m[r_idx[c_aw-1:0]] : '0;

endmodule

`default_nettype wire
